// File: rtl/program_sequencer.sv
// program_sequencer: instruction-supply stage for the 16-bit CPU.
// Holds a loadable program memory, feeds instruction/immediate words on din,
// drives run, advances pc on CPU done and on its own mvi decode, stops on a
// halt word and flags a CPU that never completes an instruction.
module program_sequencer #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16,
    parameter int WDOG   = 3
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              done,
    output logic [DATA_W-1:0] din,
    output logic              run,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              halted,
    output logic              fault,
    output logic [15:0]       instr_count
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int WD_W  = (WDOG < 2) ? 1 : $clog2(WDOG + 1);

    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [15:0]       cnt_q, cnt_d;
    logic              fault_q, fault_d;
    logic [WD_W-1:0]   wd_q, wd_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] cur_word;
    logic [2:0]        opcode;
    logic              ctrl_idle;

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign cur_word  = mem[pc_q];
    assign opcode    = cur_word[8:6];
    assign ctrl_idle = (state_q == S_IDLE) || (state_q == S_HALT);

    // Program memory: writable only while the sequencer is not executing; never cleared.
    always_ff @(posedge clk) begin
        if (load_en && ctrl_idle) begin
            mem[load_addr] <= load_data;
        end
    end

    // Control state register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
            wd_q    <= wd_d;
        end
    end

    // Next-state and output decode; run/din in ISSUE follow mem[pc] directly.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        wd_d    = wd_q;
        din     = '0;
        run     = 1'b0;
        busy    = 1'b0;
        halted  = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                halted = (state_q == S_HALT);
                if (start) begin
                    state_d = S_ISSUE;
                    pc_d    = '0;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            S_ISSUE: begin
                busy = 1'b1;
                din  = cur_word;
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else begin
                    run     = 1'b1;
                    state_d = S_EXEC;
                    wd_d    = WD_W'(1);
                    // mvi: step pc onto the immediate so it is on din during EXEC
                    if (opcode == OP_MVI) begin
                        pc_d = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_EXEC: begin
                busy = 1'b1;
                run  = 1'b1;
                din  = cur_word;
                if (done) begin
                    pc_d    = pc_q + ADDR_W'(1);
                    cnt_d   = sat_inc16(cnt_q);
                    state_d = S_ISSUE;
                end else if (wd_q == WD_W'(WDOG)) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc          = pc_q;
    assign fault       = fault_q;
    assign instr_count = cnt_q;

endmodule
